fpu_issue_ctrl: RTL and testbench

- Operand issue and result capture stage placed directly upstream of the fpu core (ports clk, A, B, opcode, O).
- Buffers incoming operations in a small FIFO and drives A/B/opcode one operation at a time.
- Holds the operands stable for the core's fixed latency, then captures O.
- Returns the result with the originating tag over a valid/ready interface.

---
 rtl/fpu_issue_ctrl.sv | 174 +++++++++++++++++
 tb/tb_fpu_issue_ctrl.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_issue_ctrl.sv
// Purpose     : queue FP operations, drive them one at a time into a fixed-latency fpu core, capture O with its tag.
// Latency     : pop -> out_valid = FPU_LATENCY cycles; accept -> out_valid >= FPU_LATENCY+1 cycles.
// Backpressure: in_ready = !full (registered count); result held in DONE while out_ready low, no new issue.
//
// Ports: clk/rst_n (async active-low); in_valid/in_ready/in_a/in_b/in_op/in_tag request side;
//        fpu_a/fpu_b/fpu_op/fpu_o core side; out_valid/out_ready/out_result/out_tag result side;
//        occupancy = FIFO entry count.
// Optional: define FPU_ISSUE_EXC_FLAGS_EN to add out_exc[2:0] = {div by zero, inf, NaN}.
module fpu_issue_ctrl #(
    parameter int DEPTH       = 4,
    parameter int FPU_LATENCY = 2,
    parameter int TAG_W       = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [31:0]                in_a,
    input  logic [31:0]                in_b,
    input  logic [1:0]                 in_op,
    input  logic [TAG_W-1:0]           in_tag,
    output logic [31:0]                fpu_a,
    output logic [31:0]                fpu_b,
    output logic [1:0]                 fpu_op,
    input  logic [31:0]                fpu_o,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_result,
    output logic [TAG_W-1:0]           out_tag,
`ifdef FPU_ISSUE_EXC_FLAGS_EN
    output logic [2:0]                 out_exc,
`endif
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int LAT_W = $clog2(FPU_LATENCY + 1);

    typedef struct packed {
        logic [31:0]      a;
        logic [31:0]      b;
        logic [1:0]       op;
        logic [TAG_W-1:0] tag;
    } entry_t;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DONE} state_t;

    // ---------------- input FIFO ----------------
    entry_t           mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full, empty, push, pop;
    entry_t           head;

    // ---------------- issue FSM ----------------
    state_t           state_q;
    logic [LAT_W-1:0] cnt_q;
    logic [TAG_W-1:0] tag_q;
    logic [31:0]      fpu_a_q, fpu_b_q;
    logic [1:0]       fpu_op_q;
    logic             out_valid_q;
    logic [31:0]      out_result_q;
    logic [TAG_W-1:0] out_tag_q;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    // Full is judged on the registered count, so a same-cycle pop never frees a slot early.
    assign push  = in_valid && !full;
    // Empty is also registered: a push into an empty FIFO becomes poppable one cycle later.
    assign pop   = !empty && ((state_q == S_IDLE) || (state_q == S_DONE && out_ready));
    assign head  = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage needs no reset: entries are only read once the count says they were written.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {in_a, in_b, in_op, in_tag};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

`ifdef FPU_ISSUE_EXC_FLAGS_EN
    logic [2:0] out_exc_q;
    logic [2:0] exc_d;
    // Flags describe the result being captured; the divisor check uses the operands still held on the core.
    assign exc_d = {(fpu_op_q == 2'b10) && (fpu_b_q[30:0] == 31'd0),
                    (fpu_o[30:23] == 8'hFF) && (fpu_o[22:0] == 23'd0),
                    (fpu_o[30:23] == 8'hFF) && (fpu_o[22:0] != 23'd0)};
    assign out_exc = out_exc_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            tag_q        <= '0;
            fpu_a_q      <= '0;
            fpu_b_q      <= '0;
            fpu_op_q     <= '0;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_tag_q    <= '0;
`ifdef FPU_ISSUE_EXC_FLAGS_EN
            out_exc_q    <= '0;
`endif
        end else begin
            // Pops happen only in IDLE or on the DONE handshake, never while counting down.
            if (pop) begin
                fpu_a_q  <= head.a;
                fpu_b_q  <= head.b;
                fpu_op_q <= head.op;
                tag_q    <= head.tag;
                cnt_q    <= LAT_W'(FPU_LATENCY);
            end
            case (state_q)
                S_IDLE: begin
                    if (pop) state_q <= S_ISSUE;
                end
                S_ISSUE: begin
                    cnt_q <= cnt_q - LAT_W'(1);
                    if (cnt_q == LAT_W'(1)) begin
                        out_result_q <= fpu_o;
                        out_tag_q    <= tag_q;
                        out_valid_q  <= 1'b1;
`ifdef FPU_ISSUE_EXC_FLAGS_EN
                        out_exc_q    <= exc_d;
`endif
                        state_q      <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= pop ? S_ISSUE : S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign in_ready   = !full;
    assign occupancy  = count_q;
    assign fpu_a      = fpu_a_q;
    assign fpu_b      = fpu_b_q;
    assign fpu_op     = fpu_op_q;
    assign out_valid  = out_valid_q;
    assign out_result = out_result_q;
    assign out_tag    = out_tag_q;

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
module tb_fpu_issue_ctrl;

    localparam int DEPTH = 4;
    localparam int LAT   = 2;
    localparam int TAG_W = 4;
    localparam int OCC_W = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [31:0]      in_a = '0;
    logic [31:0]      in_b = '0;
    logic [1:0]       in_op = '0;
    logic [TAG_W-1:0] in_tag = '0;
    logic [31:0]      fpu_a, fpu_b, fpu_o;
    logic [1:0]       fpu_op;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [31:0]      out_result;
    logic [TAG_W-1:0] out_tag;
    logic [OCC_W-1:0] occupancy;
`ifdef FPU_ISSUE_EXC_FLAGS_EN
    logic [2:0]       out_exc;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fpu_issue_ctrl #(.DEPTH(DEPTH), .FPU_LATENCY(LAT), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_tag(in_tag),
        .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_op(fpu_op), .fpu_o(fpu_o),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_tag(out_tag),
`ifdef FPU_ISSUE_EXC_FLAGS_EN
        .out_exc(out_exc),
`endif
        .occupancy(occupancy)
    );

    // ---------------- fpu core stand-in ----------------
    // Known IEEE vectors return their true result; anything else gets a deterministic mix.
    function automatic logic [31:0] fpu_fn(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
        if (a == 32'h3F800000 && b == 32'h40000000 && op == 2'b00) return 32'h40400000;
        if (a == 32'h40000000 && b == 32'h40400000 && op == 2'b11) return 32'h40C00000;
        if (a == 32'h3F800000 && b == 32'h00000000 && op == 2'b10) return 32'h7F800000;
        if (a == 32'h7FC00000 && b == 32'h3F800000 && op == 2'b01) return 32'h7FC00000;
        return (a ^ {b[15:0], b[31:16]}) + ({30'd0, op} * 32'h01000193);
    endfunction

`ifdef FPU_ISSUE_EXC_FLAGS_EN
    function automatic logic [2:0] exc_fn(input logic [31:0] r, input logic [31:0] b, input logic [1:0] op);
        return {op == 2'b10 && b[30:0] == 31'd0,
                r[30:23] == 8'hFF && r[22:0] == 23'd0,
                r[30:23] == 8'hFF && r[22:0] != 23'd0};
    endfunction
`endif

    // Output is garbage until the inputs have been stable for LAT cycles.
    logic [65:0] fpu_in_prev = '0;
    int          fpu_age = 1000;
    always @(negedge clk) begin
        if ({fpu_a, fpu_b, fpu_op} !== fpu_in_prev) begin
            fpu_in_prev = {fpu_a, fpu_b, fpu_op};
            fpu_age = 1;
        end else if (fpu_age < 1000) begin
            fpu_age++;
        end
    end
    assign fpu_o = (fpu_age >= LAT) ? fpu_fn(fpu_a, fpu_b, fpu_op) : 32'hDEADBEEF;

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [31:0]      a;
        logic [31:0]      b;
        logic [1:0]       op;
        logic [TAG_W-1:0] tag;
        logic [31:0]      res;
        logic [2:0]       exc;
    } vec_t;

    typedef struct {
        logic [31:0]      res;
        logic [TAG_W-1:0] tag;
    } exp_t;

    vec_t vecs[6];
    exp_t sbq[$];

    // One operation through an idle, empty block with out_ready high.
    task automatic run_single(input vec_t v);
        in_a = v.a; in_b = v.b; in_op = v.op; in_tag = v.tag;
        in_valid = 1'b1; out_ready = 1'b1;
        chk("single_in_ready", in_ready, 1);
        step();                                    // accept edge
        in_valid = 1'b0;
        chk("single_occ_after_push", occupancy, 1);
        chk("single_no_fallthrough", out_valid, 0);
        step();                                    // pop edge
        chk("single_occ_after_pop", occupancy, 0);
        chk("single_fpu_a", fpu_a, v.a);
        chk("single_fpu_b", fpu_b, v.b);
        chk("single_fpu_op", fpu_op, v.op);
        for (int k = 1; k < LAT; k++) begin
            step();
            chk("single_early_valid", out_valid, 0);
            chk("single_fpu_a_hold", fpu_a, v.a);
        end
        step();                                    // pop + LAT
        chk("single_valid", out_valid, 1);
        chk("single_result", out_result, v.res);
        chk("single_tag", out_tag, v.tag);
`ifdef FPU_ISSUE_EXC_FLAGS_EN
        chk("single_exc", out_exc, v.exc);
`endif
        step();
        chk("single_valid_drop", out_valid, 0);
        chk("single_fpu_a_kept", fpu_a, v.a);
    endtask

    initial begin
        int         acc;
        int         got;
        int         last_c;
        int         seen;
        int         n;
        bit         hold;
        logic [31:0]      pres;
        logic [TAG_W-1:0] ptag;
        logic [31:0]      fres[6];
        exp_t       e;

        vecs[0] = '{32'h3F800000, 32'h40000000, 2'b00, 4'd5,  32'h40400000, 3'b000};
        vecs[1] = '{32'h40000000, 32'h40400000, 2'b11, 4'd9,  32'h40C00000, 3'b000};
        vecs[2] = '{32'h3F800000, 32'h00000000, 2'b10, 4'd2,  32'h7F800000, 3'b110};
        vecs[3] = '{32'h7FC00000, 32'h3F800000, 2'b01, 4'd3,  32'h7FC00000, 3'b001};
        vecs[4] = '{32'h40000000, 32'h80000000, 2'b10, 4'd15, 32'h0,        3'b000};
        vecs[5] = '{32'h12345678, 32'h9ABCDEF0, 2'b01, 4'd0,  32'h0,        3'b000};
        for (int i = 4; i < 6; i++) begin
            vecs[i].res = fpu_fn(vecs[i].a, vecs[i].b, vecs[i].op);
`ifdef FPU_ISSUE_EXC_FLAGS_EN
            vecs[i].exc = exc_fn(vecs[i].res, vecs[i].b, vecs[i].op);
`endif
        end

        // ---------------- reset ----------------
        #12;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_fpu_a", fpu_a, 0);
        chk("rst_fpu_b", fpu_b, 0);
        chk("rst_fpu_op", fpu_op, 0);
        chk("rst_occupancy", occupancy, 0);
        chk("rst_out_result", out_result, 0);
        chk("rst_out_tag", out_tag, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("rst_in_ready", in_ready, 1);

        // ---------------- table-driven single ops ----------------
        for (int i = 0; i < 6; i++) run_single(vecs[i]);

        // ---------------- fill with out_ready low ----------------
        out_ready = 1'b0;
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            in_a = 32'h41000000 + i; in_b = 32'h3F000000 + 3 * i;
            in_op = i[1:0]; in_tag = TAG_W'(i); in_valid = 1'b1;
            if (in_ready) begin
                fres[acc] = fpu_fn(in_a, in_b, in_op);
                acc++;
            end
            step();
        end
        in_valid = 1'b0;
        chk("fill_accepted", acc, 5);
        chk("fill_in_ready", in_ready, 0);
        chk("fill_occupancy", occupancy, 4);
        chk("fill_first_valid", out_valid, 1);
        out_ready = 1'b1;
        got = 0; last_c = 0;
        for (int c = 0; c < 100 && got < 5; c++) begin
            if (out_valid) begin
                chk("fill_result", out_result, fres[got]);
                chk("fill_tag", out_tag, got);
                if (got > 0) chk("fill_period", c - last_c, LAT + 1);
                last_c = c;
                got++;
            end
            step();
            if (c == 0) chk("fill_in_ready_after_pop", in_ready, 1);
        end
        chk("fill_drain_count", got, 5);
        chk("fill_drain_occ", occupancy, 0);

        // ---------------- backpressure ----------------
        out_ready = 1'b0;
        in_a = 32'h40000000; in_b = 32'h40400000; in_op = 2'b11; in_tag = 4'd7; in_valid = 1'b1;
        step();
        in_a = 32'h3F800000; in_b = 32'h40000000; in_op = 2'b00; in_tag = 4'd8;
        step();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 30) begin step(); n++; end
        chk("bp_valid_seen", out_valid, 1);
        for (int c = 0; c < 10; c++) begin
            chk("bp_valid_hold", out_valid, 1);
            chk("bp_result_hold", out_result, 32'h40C00000);
            chk("bp_tag_hold", out_tag, 7);
            chk("bp_fpu_a_hold", fpu_a, 32'h40000000);
            chk("bp_fpu_b_hold", fpu_b, 32'h40400000);
            chk("bp_occ_hold", occupancy, 1);
            step();
        end
        out_ready = 1'b1;
        step();
        chk("bp_release_valid", out_valid, 0);
        chk("bp_next_issue_a", fpu_a, 32'h3F800000);
        chk("bp_next_issue_op", fpu_op, 2'b00);
        chk("bp_next_occ", occupancy, 0);
        n = 0;
        while (!out_valid && n < 30) begin step(); n++; end
        chk("bp_next_latency", n, LAT);
        chk("bp_next_result", out_result, 32'h40400000);
        chk("bp_next_tag", out_tag, 8);
        step();

        // ---------------- reset mid-operation ----------------
        out_ready = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_a = 32'h40800000 + i; in_b = 32'h40A00000; in_op = 2'b11; in_tag = TAG_W'(10 + i);
            step();
        end
        in_valid = 1'b0;
        chk("midrst_occ_before", occupancy, 2);
        #3;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_fpu_a", fpu_a, 0);
        chk("midrst_fpu_b", fpu_b, 0);
        chk("midrst_fpu_op", fpu_op, 0);
        chk("midrst_occ", occupancy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        step();
        chk("midrst_in_ready", in_ready, 1);
        seen = 0;
        for (int c = 0; c < 20; c++) begin
            if (out_valid) seen++;
            step();
        end
        chk("midrst_no_result", seen, 0);
        chk("midrst_occ_after", occupancy, 0);

        // ---------------- randomized against queue model ----------------
        for (int c = 0; c < 400; c++) begin
            in_valid  = ($urandom_range(0, 2) != 0);
            in_a      = $urandom;
            in_b      = $urandom;
            in_op     = 2'($urandom_range(0, 3));
            in_tag    = TAG_W'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            chk("rnd_in_ready_vs_occ", in_ready, occupancy != OCC_W'(DEPTH));
            if (in_valid && in_ready) sbq.push_back('{fpu_fn(in_a, in_b, in_op), in_tag});
            if (out_valid && out_ready) begin
                chk("rnd_sb_nonempty", sbq.size() > 0, 1);
                if (sbq.size() > 0) begin
                    e = sbq.pop_front();
                    chk("rnd_result", out_result, e.res);
                    chk("rnd_tag", out_tag, e.tag);
                end
            end
            hold = out_valid && !out_ready;
            pres = out_result;
            ptag = out_tag;
            step();
            if (hold) begin
                chk("rnd_hold_valid", out_valid, 1);
                chk("rnd_hold_result", out_result, pres);
                chk("rnd_hold_tag", out_tag, ptag);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 200 && sbq.size() > 0; c++) begin
            if (out_valid) begin
                e = sbq.pop_front();
                chk("rnd_drain_result", out_result, e.res);
                chk("rnd_drain_tag", out_tag, e.tag);
            end
            step();
        end
        chk("rnd_drain_empty", sbq.size(), 0);
        step();
        chk("rnd_final_valid", out_valid, 0);
        chk("rnd_final_occ", occupancy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
